// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions used by the fetch queue.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  // addi x0, x0, 0: presented to decode whenever the queue holds nothing.
  localparam logic [RV_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] pc4;
    logic [RV_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, pc+4, instr} between fetch
// and decode. All outputs derive from registered state only.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_pc4,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc4,
  output logic [XLEN-1:0]            out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head;

  logic push;
  logic pop;
  logic full;
  logic empty;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign stall_cnt = stall_cnt_q;

  // Next-state for pointers, occupancy and the stall counter; flush wins over push/pop.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stall_cnt_d = stall_cnt_q + {31'd0, (in_valid && !in_ready)};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // State registers with synchronous reset; reset also clears the stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Entry storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem_q[wr_ptr_q] <= '{pc: in_pc, pc4: in_pc4, instr: in_instr};
    end
  end

  // Head presentation: fixed NOP/zero outputs while empty.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_pc    = '0;
    out_pc4   = '0;
    out_instr = NOP_INSTR;
    if (!empty) begin
      out_pc    = head.pc;
      out_pc4   = head.pc4;
      out_instr = head.instr;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the PC/instruction-memory fetch stage and decode. Captures the fetch stage's `{pc, pc+4, instruction}` triple each cycle it is accepted and presents entries in order to decode over a valid/ready handshake. This decouples fetch from decode stalls. A redirect (taken branch/jump) flushes every queued entry in one cycle.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; a power of two, at least 2.
- `XLEN`, 32: width of pc and instruction.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `flush`  in  1  redirect: discard all entries. Driven high for the cycle in which fetch loads a branch/jump target.
- `in_valid`  in  1  fetch presents an entry.
- `in_pc`  in  XLEN  pc of the fetched instruction.
- `in_pc4`  in  XLEN  pc+4 of the fetched instruction.
- `in_instr`  in  XLEN  instruction word from instruction memory.
- `in_ready`  out  1  queue can accept an entry.
- `out_valid`  out  1  head entry available to decode.
- `out_pc`  out  XLEN  head entry pc.
- `out_pc4`  out  XLEN  head entry pc+4.
- `out_instr`  out  XLEN  head entry instruction.
- `out_ready`  in  1  decode consumes the head this cycle.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `stall_cnt`  out  32  cycles in which `in_valid && !in_ready`.

## Operation
- A push occurs when `in_valid && in_ready`. A pop occurs when `out_valid && out_ready`.
- Storage is a circular buffer with write and read pointers of width $clog2(DEPTH), which wrap modulo DEPTH.
- `count` is a register:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- `in_ready` = (count != DEPTH). It depends only on registered state and never on `out_ready`.
- `out_valid` = (count != 0).
- When `out_valid` is 1, `out_pc`/`out_pc4`/`out_instr` show the entry at the read pointer.
- When `out_valid` is 0, the outputs are fixed:
  - `out_instr` = NOP_INSTR (32'h0000_0013)
  - `out_pc` = 0
  - `out_pc4` = 0
- Flush has priority over everything else. In a flush cycle:
  - any push is discarded and any pop is ignored;
  - the next state is count=0 with both pointers at 0.
- `stall_cnt` increments in each cycle where `in_valid && !in_ready`. It wraps at 2^32. Flush does not clear it; only reset does.
- Reset values:
  - count=0, pointers=0, stall_cnt=0
  - `out_valid`=0, `in_ready`=1
  - `out_instr`=NOP_INSTR, `out_pc`=0, `out_pc4`=0
  - Storage contents are not cleared.
- Asserting reset mid-operation behaves like flush and also clears `stall_cnt`. Reset has priority over flush.

## Timing
- Latency: an entry pushed at edge N is visible with `out_valid`=1 in the cycle after edge N. There is no same-cycle bypass.
- Full (count==DEPTH):
  - `in_ready`=0;
  - a pop in that cycle does not allow a simultaneous push;
  - `in_ready` returns to 1 in the cycle after the pop.
- Empty (count==0): `out_valid`=0; a push in that cycle is not visible until the next cycle.
- Pointer wrap: after DEPTH pushes, the write pointer returns to 0 with no gap or duplication.
- Flush at edge N: `out_valid`=0, `in_ready`=1 and count=0 in the cycle after edge N. An entry pushed in the cycle after the flush appears one cycle later still.
- Every output is a function of registered state only. There is no combinational path from inputs to outputs.

## Structure
- Shared package `riscv_pkg` holds:
  - `NOP_INSTR` (32'h0000_0013);
  - typedef `fetch_entry_t` (struct of pc, pc4, instr; XLEN each).
- Storage is an array of `fetch_entry_t` inside the module.
- No sub-module. The pointer/count logic is small enough to stay inline.

## Test plan
- Reset, then 3 consecutive pushes (pc 0x0, 0x4, 0x8) with `out_ready`=0 → count=3, `out_valid`=1, `out_pc`=0x0, `out_pc4`=0x4.
- Push 4 entries with DEPTH=4 and hold `in_valid`=1 for 3 more cycles with `out_ready`=0 → `in_ready`=0, count=4, `stall_cnt`=3. Then one pop → `in_ready`=1 on the next cycle.
- Continuous push and pop for 10 cycles (pc 0x0..0x24) → `out_pc` sequence 0x0..0x24 in order, count steady at 1, pointers wrap cleanly.
- With 3 entries queued, assert `flush` together with a push of pc 0x40 → next cycle count=0, `out_valid`=0, `out_instr`=0x00000013. A push of 0x40 in the following cycle then appears at the head.
- Assert `rst` mid-stream with 2 entries queued and `stall_cnt`=5 → next cycle count=0, `stall_cnt`=0, `in_ready`=1, `out_pc`=0.
